// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state, Booth digit types and radix-4 triplet recoding
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {ZERO, POS1, NEG1, POS2, NEG2} digit_e;
  function automatic digit_e booth_recode(input logic [2:0] t);
    return (t == 3'b011) ? POS2 :
           (t == 3'b100) ? NEG2 :
           (t == 3'b000 || t == 3'b111) ? ZERO :
           t[2] ? NEG1 : POS1;
  endfunction
endpackage

// File: rtl/booth_r4_pp.sv
// booth_r4_pp: maps a radix-4 Booth triplet and extended multiplicand to a sign-extended partial product
module booth_r4_pp
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]         i_trip,
  input  logic [WIDTH+1:0]   i_m,
  output logic [2*WIDTH-1:0] o_pp
);
  localparam logic [2*WIDTH-1:0] ONE = 1;
  digit_e             w_d;
  logic [2*WIDTH-1:0] w_m1;
  logic [2*WIDTH-1:0] w_m2;
  assign w_d  = booth_recode(i_trip);
  assign w_m1 = {{(WIDTH-2){i_m[WIDTH+1]}}, i_m};
  assign w_m2 = w_m1 << 1;
  // select the multiple of M for the recoded digit; negation is invert plus one
  always_comb
    o_pp = (w_d == POS1) ? w_m1 :
           (w_d == NEG1) ? ~w_m1 + ONE :
           (w_d == POS2) ? w_m2 :
           (w_d == NEG2) ? ~w_m2 + ONE : '0;
endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential radix-4 Booth multiplier, WIDTH/2+1 digit cycles; BOOTH_UNSIGNED_EN adds an is_signed input
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   R,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy
);
  localparam int N = WIDTH / 2 + 1;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_e             r_state;
  state_e             w_next;
  logic [WIDTH+1:0]   r_m;
  logic [WIDTH+2:0]   r_y;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_sum;
  logic               w_sx;
  logic               w_last;
`ifdef BOOTH_UNSIGNED_EN
  assign w_sx = is_signed;
`else
  assign w_sx = 1'b1;
`endif
  assign w_last = r_cnt == LAST;
  assign w_sum  = r_acc + (w_pp << {r_cnt, 1'b0});
  assign P      = r_p;
  booth_r4_pp #(.WIDTH(WIDTH)) u_pp (
    .i_trip (r_y[2:0]),
    .i_m    (r_m),
    .o_pp   (w_pp)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next state; clear wins over any handshake
  always_comb
    w_next = clear ? IDLE :
             (r_state == IDLE && in_valid) ? CALC :
             (r_state == CALC && w_last) ? DONE :
             (r_state == DONE && out_ready) ? IDLE : r_state;
  // handshake and status outputs decoded from state
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state == CALC || r_state == DONE;
  end
  // datapath: load operands on acceptance, one Booth digit per CALC cycle, capture product on entry to DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_m   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else if (r_state == IDLE && w_next == CALC) begin
      r_m   <= {{2{w_sx & M[WIDTH-1]}}, M};
      r_y   <= {{2{w_sx & R[WIDTH-1]}}, R, 1'b0};
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == CALC && !clear) begin
      r_acc <= w_sum;
      r_y   <= {2'b00, r_y[WIDTH+2:2]};
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_p <= w_sum;
    end
endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: randomized and directed checks of booth_seq_mul against an arithmetic product model
module tb_booth_seq_mul;
  localparam int W = 16;
  localparam int LAT = W / 2 + 2;
  logic           clk = 0;
  logic           rst = 1;
  logic           clear = 0;
  logic           in_valid = 0;
  logic           out_ready = 0;
  logic           is_signed = 1;
  logic [W-1:0]   m = '0;
  logic [W-1:0]   r = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] p;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_seq_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M         (m),
    .R         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (p),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [2*W-1:0] x;
    logic signed [2*W-1:0] y;
    x = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    y = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return x * y;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check("accept_ready", in_ready, 1);
    m = a;
    r = b;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input logic [2*W-1:0] exp);
    logic [2*W-1:0] prev = p;
    int cyc = 1;
    bit calc_ok = 1;
    bit hold_ok = 1;
    accept(a, b);
    while (!out_valid && cyc < 40) begin
      if (p !== prev || in_ready || !busy) calc_ok = 0;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_product"}, p, exp);
    check({tag, "_calc_hold"}, calc_ok, 1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      tick();
      if (p !== exp || !out_valid || in_ready || !busy) hold_ok = 0;
    end
    in_valid = 0;
    if (hold > 0) check({tag, "_done_hold"}, hold_ok, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    check({tag, "_idle_ready"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  task automatic abort(input bit use_rst);
    logic [2*W-1:0] prev = p;
    bit quiet = 1;
    accept(16'd5, 16'd7);
    tick();
    tick();
    tick();
    if (use_rst) begin
      rst = 1;
      #1;
      check("rst_async_flags", {in_ready, out_valid, busy}, 3'b100);
      check("rst_async_p", p, 0);
      @(negedge clk);
      rst = 0;
      tick();
    end else begin
      clear = 1;
      tick();
      clear = 0;
      check("clear_flags", {in_ready, out_valid, busy}, 3'b100);
      check("clear_p_kept", p, prev);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) quiet = 0;
    end
    check(use_rst ? "rst_no_output" : "clear_no_output", quiet, 1);
    run_op(use_rst ? "after_rst" : "after_clear", 16'd2, 16'hFFFD, 0, 32'hFFFFFFFA);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #12;
    check("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("reset_p", p, 0);
    @(negedge clk);
    rst = 0;
    tick();
    run_op("m3_r5", 16'd3, 16'd5, 0, 32'h0000000F);
    run_op("minmin", 16'h8000, 16'h8000, 0, 32'h40000000);
    run_op("max_min", 16'h7FFF, 16'h8000, 0, 32'hC0008000);
    run_op("neg1_x1", 16'hFFFF, 16'h0001, 5, 32'hFFFFFFFF);
    abort(0);
    abort(1);
    clear = 1;
    in_valid = 1;
    tick();
    clear = 0;
    in_valid = 0;
    check("clear_beats_in_valid", {in_ready, busy}, 2'b10);
    accept(16'd9, 16'd9);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("pre_clear_done", {out_valid, p}, {1'b1, 32'd81});
    clear = 1;
    out_ready = 1;
    tick();
    clear = 0;
    out_ready = 0;
    check("clear_in_done", {in_ready, out_valid, p}, {2'b10, 32'd81});
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a = W'($urandom);
      logic [W-1:0] b = W'($urandom);
      if (k % 8 == 0) a = 16'h8000;
      if (k % 8 == 1) b = 16'h7FFF;
      run_op("rand", a, b, $urandom_range(0, 3), ref_mul(a, b, is_signed));
    end
`ifdef BOOTH_UNSIGNED_EN
    is_signed = 0;
    run_op("uns_ffff", 16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001);
    for (int k = 0; k < 10; k++) begin
      logic [W-1:0] a = W'($urandom);
      logic [W-1:0] b = W'($urandom);
      run_op("uns_rand", a, b, 0, ref_mul(a, b, 1'b0));
    end
    is_signed = 1;
    run_op("sgn_ffff", 16'hFFFF, 16'hFFFF, 0, 32'h00000001);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
